key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//   Conditions the raw push-button "key" input before it reaches the two-digit
//   BCD press counter.
//   Synchronises the asynchronous pad signal, rejects contact bounce and emits
//   exactly one single-cycle key_pulse per confirmed press.
//   Optional auto-repeat emits further pulses while the key is held.
//   Downstream counters increment on key_pulse in the clk domain, so they never
//   need to clock from the key pin itself.
// PARAMETERS
//   DEB_CYCLES     1000000  stable cycles needed to confirm press/release (20 ms @ 50 MHz); >=2
//   REPEAT_EN      0        1 = auto-repeat pulses while held, 0 = none
//   REPEAT_DELAY   25000000 cycles from press pulse to first repeat pulse; >=2
//   REPEAT_PERIOD  5000000  cycles between subsequent repeat pulses; >=2
//   CNT_W          26       counter width; must hold max(DEB_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)
// PORTS
//   clk        in   1  system clock, all state on rising edge
//   res        in   1  asynchronous active-low reset (0 = reset)
//   key        in   1  raw button level, asynchronous, 1 = pressed
//   key_level  out  1  debounced key level
//   key_pulse  out  1  one-cycle strobe per confirmed press and per repeat
//   rel_pulse  out  1  one-cycle strobe per confirmed release
// BEHAVIOUR
//   Reset (res=0, async)
//   - All outputs are 0; state=IDLE; both counters are 0; both sync flops are 0.
//   Synchroniser
//   - Two flops: key -> s1 -> key_sync.
//   - The FSM looks only at key_sync.
//   FSM states
//   - IDLE: key_level=0.
//     - key_sync=1 -> PRESS_CHK, deb_cnt=0.
//   - PRESS_CHK: counts while key_sync=1.
//     - key_sync=0 -> IDLE, deb_cnt=0. This rejects the glitch; no pulse.
//     - deb_cnt==DEB_CYCLES-1 with key_sync=1 -> HELD, key_level=1, key_pulse=1 for one cycle, rpt_cnt=0.
//   - HELD: key_level=1.
//     - key_sync=0 -> REL_CHK, deb_cnt=0.
//     - Otherwise, when REPEAT_EN=1, rpt_cnt increments each cycle.
//   - REL_CHK: key_level stays 1; counts while key_sync=0.
//     - key_sync=1 -> HELD, deb_cnt=0. rpt_cnt is frozen, not cleared.
//     - deb_cnt==DEB_CYCLES-1 with key_sync=0 -> IDLE, key_level=0, rel_pulse=1 for one cycle.
//   Latency
//   - key is first sampled high at edge E1.
//   - key_pulse is high in the cycle after edge E(DEB_CYCLES+3).
//   - Release uses the same figure.
//   Auto-repeat (REPEAT_EN=1 only)
//   - First repeat key_pulse comes REPEAT_DELAY cycles after the press pulse.
//   - rpt_cnt then reloads to 0 and later pulses come every REPEAT_PERIOD cycles.
//   - A 1-bit phase flag selects the DELAY or PERIOD compare.
//   - The phase flag clears on entry to HELD from PRESS_CHK.
//   Pulse rules
//   - key_pulse and rel_pulse are registered, never both 1, and each lasts exactly one cycle.
//   - With REPEAT_EN=0, rpt_cnt stays at 0 and the only key_pulse is the press pulse.
//   Counter width
//   - Counters never wrap: they are cleared on every state change and compare with ==.
//   Reset mid-operation
//   - Any state returns to IDLE immediately with outputs at 0.
//   - If key is still held after reset release, a full new press is required: sync, then DEB_CYCLES.
// TESTING (bench params: DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1 unless noted)
//   1. Reset: res=0 with key=1 for 5 cycles -> key_level=0, key_pulse=0, rel_pulse=0 throughout.
//   2. Clean press: key 0->1 before edge E1 and held -> key_pulse=1 only in the cycle after E7;
//      key_level=1 from E7.
//   3. Bounce: key high 3 cycles, low 1, then high steadily -> no pulse before steady;
//      exactly one key_pulse, 4+3 cycles after the steady high begins.
//   4. Release: after scenario 2, key=0 steadily -> rel_pulse exactly once after 7 edges;
//      key_level falls in the same cycle.
//   5. Auto-repeat: hold key -> press pulse at P, then pulses at P+10, P+13, P+16.
//      REPEAT_EN=0 -> only the pulse at P.
//   6. Reset mid-hold: res=0 for 2 cycles in HELD with key=1 -> outputs 0 at once;
//      after release, key_pulse appears 7 edges later.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM and optional
// auto-repeat, producing a debounced level plus single-cycle press/release strobes.
module key_debounce #(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic res,
    input  logic key,
    output logic key_level,
    output logic key_pulse,
    output logic rel_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    // Counters compare against "last" values so a terminal count fires on the N-th cycle.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             phase_q, phase_d;
    logic             s1_q, key_sync_q;
    logic             key_level_q, key_level_d;
    logic             key_pulse_q, key_pulse_d;
    logic             rel_pulse_q, rel_pulse_d;
    logic [CNT_W-1:0] rpt_last_c;

    // Metastability guard on the asynchronous pad.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1_q       <= 1'b0;
            key_sync_q <= 1'b0;
        end else begin
            s1_q       <= key;
            key_sync_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= IDLE;
            deb_cnt_q   <= CNT_ZERO;
            rpt_cnt_q   <= CNT_ZERO;
            phase_q     <= 1'b0;
            key_level_q <= 1'b0;
            key_pulse_q <= 1'b0;
            rel_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            phase_q     <= phase_d;
            key_level_q <= key_level_d;
            key_pulse_q <= key_pulse_d;
            rel_pulse_q <= rel_pulse_d;
        end
    end

    // Phase 0 waits the initial hold delay, phase 1 the shorter repeat period.
    assign rpt_last_c = phase_q ? PER_LAST : DLY_LAST;

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        rpt_cnt_d   = rpt_cnt_q;
        phase_d     = phase_q;
        key_level_d = key_level_q;
        key_pulse_d = 1'b0;
        rel_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                key_level_d = 1'b0;
                if (key_sync_q) begin
                    state_d   = PRESS_CHK;
                    deb_cnt_d = CNT_ZERO;
                end
            end
            PRESS_CHK: begin
                if (!key_sync_q) begin
                    state_d   = IDLE;
                    deb_cnt_d = CNT_ZERO;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    deb_cnt_d   = CNT_ZERO;
                    rpt_cnt_d   = CNT_ZERO;
                    phase_d     = 1'b0;
                    key_level_d = 1'b1;
                    key_pulse_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                key_level_d = 1'b1;
                if (!key_sync_q) begin
                    state_d   = REL_CHK;
                    deb_cnt_d = CNT_ZERO;
                end else if (REPEAT_EN != 0) begin
                    if (rpt_cnt_q == rpt_last_c) begin
                        rpt_cnt_d   = CNT_ZERO;
                        phase_d     = 1'b1;
                        key_pulse_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                    end
                end
            end
            REL_CHK: begin
                key_level_d = 1'b1;
                if (key_sync_q) begin
                    state_d   = HELD;
                    deb_cnt_d = CNT_ZERO;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    deb_cnt_d   = CNT_ZERO;
                    key_level_d = 1'b0;
                    rel_pulse_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = CNT_ZERO;
            end
        endcase
    end

    assign key_level = key_level_q;
    assign key_pulse = key_pulse_q;
    assign rel_pulse = rel_pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected strobes are queued with their
// edge number when stimulus is applied and matched as the DUT emits them.
module tb_key_debounce;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;
    localparam int unsigned LAT = DEB + 3;

    logic clk = 1'b0;
    logic res;
    logic key;
    logic key_level, key_pulse, rel_pulse;
    logic nr_level, nr_pulse, nr_rel;

    typedef struct {
        logic        rel;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int unsigned ecnt     = 0;
    int unsigned nr_cnt   = 0;
    int          n_checks = 0;
    int          n_err    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    key_debounce #(
        .DEB_CYCLES(DEB), .REPEAT_EN(1), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .CNT_W(8)
    ) dut (
        .clk(clk), .res(res), .key(key),
        .key_level(key_level), .key_pulse(key_pulse), .rel_pulse(rel_pulse)
    );

    key_debounce #(
        .DEB_CYCLES(DEB), .REPEAT_EN(0), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .CNT_W(8)
    ) dut_nr (
        .clk(clk), .res(res), .key(key),
        .key_level(nr_level), .key_pulse(nr_pulse), .rel_pulse(nr_rel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, ecnt);
        end
    endtask

    task automatic push(input logic rel, input int unsigned at);
        exp_t x;
        x.rel = rel;
        x.at  = at;
        exp_q.push_back(x);
    endtask

    task automatic wait_to(input int unsigned t);
        while (ecnt < t) @(negedge clk);
    endtask

    // Every strobe seen must be the oldest outstanding expectation, at its exact edge.
    always @(negedge clk) begin
        if (res === 1'b1 && (key_pulse === 1'b1 || rel_pulse === 1'b1)) begin
            check("pulse_exclusive", 32'(key_pulse & rel_pulse), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_edge", ecnt, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pulse_is_release", 32'(rel_pulse), 32'(e.rel));
                check("pulse_edge", ecnt, e.at);
            end
        end
        if (nr_pulse === 1'b1) nr_cnt <= nr_cnt + 1;
    end

    initial begin
        int unsigned t0, t1, p, nr0;
        res = 1'b0;
        key = 1'b1;

        // Reset held with key pressed: everything stays quiet.
        repeat (5) begin
            @(negedge clk);
            check("rst_outputs", 32'({key_level, key_pulse, rel_pulse}), 32'd0);
            check("rst_outputs_nr", 32'({nr_level, nr_pulse, nr_rel}), 32'd0);
        end
        key = 1'b0;
        @(negedge clk);
        res = 1'b1;
        repeat (4) @(negedge clk);

        // Clean press, then release before any repeat can fire.
        key = 1'b1;
        t0  = ecnt;
        push(1'b0, t0 + LAT);
        wait_to(t0 + LAT - 1);
        check("press_level_before", 32'(key_level), 32'd0);
        wait_to(t0 + LAT);
        check("press_level_after", 32'(key_level), 32'd1);
        wait_to(t0 + LAT + 1);
        key = 1'b0;
        t1  = ecnt;
        push(1'b1, t1 + LAT);
        wait_to(t1 + LAT - 1);
        check("release_level_before", 32'(key_level), 32'd1);
        wait_to(t1 + LAT);
        check("release_level_after", 32'(key_level), 32'd0);
        wait_to(t1 + LAT + 4);

        // Bounce: 3 high, 1 low, then steady high.
        key = 1'b1;
        repeat (3) @(negedge clk);
        key = 1'b0;
        @(negedge clk);
        key = 1'b1;
        t0  = ecnt;
        push(1'b0, t0 + LAT);
        wait_to(t0 + LAT - 1);
        check("bounce_level_before", 32'(key_level), 32'd0);
        wait_to(t0 + LAT + 1);
        key = 1'b0;
        t1  = ecnt;
        push(1'b1, t1 + LAT);
        wait_to(t1 + LAT + 4);

        // Auto-repeat while held; the REPEAT_EN=0 instance pulses once only.
        nr0 = nr_cnt;
        key = 1'b1;
        t0  = ecnt;
        p   = t0 + LAT;
        push(1'b0, p);
        push(1'b0, p + RD);
        push(1'b0, p + RD + RP);
        push(1'b0, p + RD + 2 * RP);
        push(1'b0, p + RD + 3 * RP);
        wait_to(p + RD + 2 * RP + 1);
        key = 1'b0;
        t1  = ecnt;
        push(1'b1, t1 + LAT);
        wait_to(t1 + LAT + 4);
        check("norepeat_pulse_count", nr_cnt - nr0, 32'd1);
        check("norepeat_level", 32'(nr_level), 32'd0);

        // Reset while held: outputs clear at once, full press needed afterwards.
        key = 1'b1;
        t0  = ecnt;
        push(1'b0, t0 + LAT);
        wait_to(t0 + LAT + 2);
        check("held_level", 32'(key_level), 32'd1);
        res = 1'b0;
        #1;
        check("midrst_outputs", 32'({key_level, key_pulse, rel_pulse}), 32'd0);
        check("midrst_outputs_nr", 32'({nr_level, nr_pulse, nr_rel}), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_hold", 32'({key_level, key_pulse, rel_pulse}), 32'd0);
        res = 1'b1;
        t0  = ecnt;
        push(1'b0, t0 + LAT);
        wait_to(t0 + LAT - 1);
        check("postrst_level_before", 32'(key_level), 32'd0);
        wait_to(t0 + LAT);
        check("postrst_level_after", 32'(key_level), 32'd1);
        wait_to(t0 + LAT + 1);
        key = 1'b0;
        t1  = ecnt;
        push(1'b1, t1 + LAT);
        wait_to(t1 + LAT + 6);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
